// File: rtl/syr2k_operand_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : syr2k_operand_sequencer
// Purpose  : Operand feeder for the syr2k compute datapath. Walks the loop
//            nest i (row), j (col), k (reduction) over N x N matrices held in
//            synchronous-read RAMs. Each beat carries
//              X = A[i][k], Y = B[i][k], XT = A[j][k], YT = B[j][k], Z = C[i][j]
//            plus first/last-k flags and the (i,j) coordinates.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   start                    one-cycle pass request, honoured only in IDLE
//   busy, done               pass in progress / one-cycle completion pulse
//   mem_en                   RAM read enable (pipeline advance)
//   a_addr0/a_addr1          A[i][k] / A[j][k] addresses
//   b_addr0/b_addr1          B[i][k] / B[j][k] addresses
//   c_addr                   C[i][j] address
//   a_rdata0..c_rdata        RAM read data, one cycle after address
//   X, Y, XT, YT, Z          registered operands
//   out_valid, out_ready     operand beat handshake
//   out_first, out_last      beat has k == 0 / k == N-1
//   out_row, out_col         i and j of the beat
// ============================================================================
module syr2k_operand_sequencer #(
  parameter int N   = 100,
  parameter int DW  = 32,
  parameter int AW  = 14,
  parameter int TRI = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_en,
  output logic [AW-1:0]        a_addr0,
  output logic [AW-1:0]        a_addr1,
  output logic [AW-1:0]        b_addr0,
  output logic [AW-1:0]        b_addr1,
  output logic [AW-1:0]        c_addr,
  input  logic [DW-1:0]        a_rdata0,
  input  logic [DW-1:0]        a_rdata1,
  input  logic [DW-1:0]        b_rdata0,
  input  logic [DW-1:0]        b_rdata1,
  input  logic [DW-1:0]        c_rdata,
  output logic [DW-1:0]        X,
  output logic [DW-1:0]        Y,
  output logic [DW-1:0]        XT,
  output logic [DW-1:0]        YT,
  output logic [DW-1:0]        Z,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_first,
  output logic                 out_last,
  output logic [$clog2(N)-1:0] out_row,
  output logic [$clog2(N)-1:0] out_col
);

  localparam int            CW     = $clog2(N);
  localparam logic [CW-1:0] K_MAX  = CW'(N - 1);
  localparam logic [AW-1:0] N_STEP = AW'(N);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // S0 index counters and row bases (i*N, j*N kept incrementally)
  logic [CW-1:0] r_i, r_j, r_k;
  logic [AW-1:0] r_in, r_jn;

  // S1 tags (addresses are the output ports themselves)
  logic          r_v1, r_first1, r_last1;
  logic [CW-1:0] r_row1, r_col1;

  // Tags travelling alongside the RAM read
  logic          r_vr, r_firstr, r_lastr;
  logic [CW-1:0] r_rowr, r_colr;

  logic w_adv, w_issue, w_k_wrap, w_j_end, w_i_wrap, w_final;

  // The whole pipeline moves together; the output register is the only
  // place a stall can originate.
  assign w_adv    = ~out_valid | out_ready;
  assign mem_en   = w_adv;
  assign w_issue  = (r_state == S_RUN) & w_adv;
  assign w_k_wrap = (r_k == K_MAX);
  assign w_i_wrap = (r_i == K_MAX);
  assign w_final  = w_k_wrap & w_j_end & w_i_wrap;

  if (TRI != 0) begin : g_tri
    assign w_j_end = (r_j == r_i);
  end else begin : g_full
    assign w_j_end = (r_j == K_MAX);
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next_state = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_issue && w_final) w_next_state = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        // With S1 and the RAM stage empty, the beat in the output register
        // is the final one; its acceptance ends the pass.
        if (!r_v1 && !r_vr && out_valid && out_ready) w_next_state = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // S0: loop counters, k innermost, then j, then i
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i  <= '0;
      r_j  <= '0;
      r_k  <= '0;
      r_in <= '0;
      r_jn <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_i  <= '0;
      r_j  <= '0;
      r_k  <= '0;
      r_in <= '0;
      r_jn <= '0;
    end else if (w_issue) begin
      if (!w_k_wrap) begin
        r_k <= r_k + CW'(1);
      end else begin
        r_k <= '0;
        if (!w_j_end) begin
          r_j  <= r_j + CW'(1);
          r_jn <= r_jn + N_STEP;
        end else begin
          r_j  <= '0;
          r_jn <= '0;
          // On the final tuple the FSM leaves RUN, so i needs no wrap.
          if (!w_i_wrap) begin
            r_i  <= r_i + CW'(1);
            r_in <= r_in + N_STEP;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // S1: addresses and tags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1     <= 1'b0;
      r_first1 <= 1'b0;
      r_last1  <= 1'b0;
      r_row1   <= '0;
      r_col1   <= '0;
      a_addr0  <= '0;
      a_addr1  <= '0;
      b_addr0  <= '0;
      b_addr1  <= '0;
      c_addr   <= '0;
    end else if (w_adv) begin
      r_v1 <= w_issue;
      if (w_issue) begin
        a_addr0  <= r_in + AW'(r_k);
        b_addr0  <= r_in + AW'(r_k);
        a_addr1  <= r_jn + AW'(r_k);
        b_addr1  <= r_jn + AW'(r_k);
        c_addr   <= r_in + AW'(r_j);
        r_first1 <= (r_k == '0);
        r_last1  <= w_k_wrap;
        r_row1   <= r_i;
        r_col1   <= r_j;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Tags shadowing the one-cycle RAM read
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vr     <= 1'b0;
      r_firstr <= 1'b0;
      r_lastr  <= 1'b0;
      r_rowr   <= '0;
      r_colr   <= '0;
    end else if (w_adv) begin
      r_vr     <= r_v1;
      r_firstr <= r_first1;
      r_lastr  <= r_last1;
      r_rowr   <= r_row1;
      r_colr   <= r_col1;
    end
  end

  // --------------------------------------------------------------------------
  // S2: output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
      X         <= '0;
      Y         <= '0;
      XT        <= '0;
      YT        <= '0;
      Z         <= '0;
    end else if (w_adv) begin
      out_valid <= r_vr;
      out_first <= r_firstr;
      out_last  <= r_lastr;
      out_row   <= r_rowr;
      out_col   <= r_colr;
      X         <= a_rdata0;
      Y         <= b_rdata0;
      XT        <= a_rdata1;
      YT        <= b_rdata1;
      Z         <= c_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_syr2k_operand_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_syr2k_operand_sequencer
// Purpose  : Scoreboard bench for syr2k_operand_sequencer. Two instances with
//            N=4: index 0 covers the full square (TRI=0), index 1 the lower
//            triangle (TRI=1). RAM contents are A[r][c]=r*4+c, B=A+100,
//            C=A+200, so each RAM word equals its address plus an offset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_syr2k_operand_sequencer;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int CW = 2;

  typedef struct packed {
    logic [31:0]   x, y, xt, yt, z;
    logic          first, last;
    logic [CW-1:0] row, col;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  int   rmode = 0;  // 0: always ready, 1: LFSR, 2: held low
  logic start_s [2];

  logic          busy [2], done_o [2], mem_en [2], vld [2], first_o [2], last_o [2];
  logic [AW-1:0] a0 [2], a1 [2], b0 [2], b1 [2], ca [2];
  logic [DW-1:0] ra0 [2], ra1 [2], rb0 [2], rb1 [2], rc [2];
  logic [DW-1:0] xo [2], yo [2], xto [2], yto [2], zo [2];
  logic [CW-1:0] row_o [2], col_o [2];

  beat_t exp_q [2][$];
  int    nbeats [2], nfirst [2], nlast [2], ndone [2];
  int    n_checks = 0;
  int    n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [DW-1:0] rd_a0 = '0, rd_a1 = '0, rd_b0 = '0, rd_b1 = '0, rd_c = '0;

    always @(posedge clk) begin
      if (mem_en[g]) begin
        rd_a0 <= DW'(a0[g]);
        rd_a1 <= DW'(a1[g]);
        rd_b0 <= DW'(b0[g]) + 32'd100;
        rd_b1 <= DW'(b1[g]) + 32'd100;
        rd_c  <= DW'(ca[g]) + 32'd200;
      end
    end

    assign ra0[g] = rd_a0;
    assign ra1[g] = rd_a1;
    assign rb0[g] = rd_b0;
    assign rb1[g] = rd_b1;
    assign rc[g]  = rd_c;

    syr2k_operand_sequencer #(.N(N), .DW(DW), .AW(AW), .TRI(g)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start_s[g]),
      .busy     (busy[g]),
      .done     (done_o[g]),
      .mem_en   (mem_en[g]),
      .a_addr0  (a0[g]),
      .a_addr1  (a1[g]),
      .b_addr0  (b0[g]),
      .b_addr1  (b1[g]),
      .c_addr   (ca[g]),
      .a_rdata0 (ra0[g]),
      .a_rdata1 (ra1[g]),
      .b_rdata0 (rb0[g]),
      .b_rdata1 (rb1[g]),
      .c_rdata  (rc[g]),
      .X        (xo[g]),
      .Y        (yo[g]),
      .XT       (xto[g]),
      .YT       (yto[g]),
      .Z        (zo[g]),
      .out_valid(vld[g]),
      .out_ready(rdy),
      .out_first(first_o[g]),
      .out_last (last_o[g]),
      .out_row  (row_o[g]),
      .out_col  (col_o[g])
    );
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_expected(input int g);
    beat_t e;
    for (int i = 0; i < N; i++)
      for (int j = 0; j <= ((g == 1) ? i : N - 1); j++)
        for (int k = 0; k < N; k++) begin
          e.x     = 32'(i * N + k);
          e.y     = 32'(i * N + k + 100);
          e.xt    = 32'(j * N + k);
          e.yt    = 32'(j * N + k + 100);
          e.z     = 32'(i * N + j + 200);
          e.first = (k == 0);
          e.last  = (k == N - 1);
          e.row   = CW'(i);
          e.col   = CW'(j);
          exp_q[g].push_back(e);
        end
  endtask

  // Compares every valid cycle (stalled or not) against the queue head, so
  // a held beat must keep matching the same expectation until accepted.
  task automatic monitor(input int g);
    beat_t e;
    logic  done_exp = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        done_exp = 1'b0;
      end else begin
        if (done_exp) begin
          check("done_after_last", done_o[g], 1);
          done_exp = 1'b0;
        end
        if (done_o[g]) ndone[g]++;
        if (vld[g]) begin
          if (exp_q[g].size() == 0) begin
            check("extra_beat", vld[g], 0);
          end else begin
            e = exp_q[g][0];
            check("X",    xo[g],  e.x);
            check("Y",    yo[g],  e.y);
            check("XT",   xto[g], e.xt);
            check("YT",   yto[g], e.yt);
            check("Z",    zo[g],  e.z);
            check("tags", {first_o[g], last_o[g], row_o[g], col_o[g]},
                          {e.first, e.last, e.row, e.col});
            if (rdy) begin
              void'(exp_q[g].pop_front());
              nbeats[g]++;
              if (first_o[g]) nfirst[g]++;
              if (last_o[g])  nlast[g]++;
              if (exp_q[g].size() == 0) done_exp = 1'b1;
            end
          end
        end
      end
    end
  endtask

  task automatic ready_drv();
    logic [15:0] lfsr = 16'hACE1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: rdy = 1'b1;
        1: begin
          lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
          rdy  = lfsr[0];
        end
        default: rdy = 1'b0;
      endcase
    end
  endtask

  // Caller is at a negedge; start is sampled on the following posedge.
  task automatic pulse_start(input int g);
    start_s[g] = 1'b1;
    @(posedge clk);
    #1 start_s[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int budget);
    int base = ndone[g];
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (ndone[g] != base) break;
    end
    check("done_seen", 32'(ndone[g] - base), 1);
  endtask

  initial begin
    int b_beats, b_done, b_first, b_last;
    start_s[0] = 1'b0;
    start_s[1] = 1'b0;
    for (int g = 0; g < 2; g++) begin
      nbeats[g] = 0; nfirst[g] = 0; nlast[g] = 0; ndone[g] = 0;
    end
    fork
      monitor(0);
      monitor(1);
      ready_drv();
    join_none

    // ---------------- reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check("rst_valid", vld[g], 0);
      check("rst_busy",  busy[g], 0);
      check("rst_done",  done_o[g], 0);
      check("rst_ops",   {xo[g], zo[g]}, 0);
      check("rst_addr",  {a0[g], a1[g], b0[g], b1[g], ca[g]}, 0);
      check("rst_tags",  {first_o[g], last_o[g], row_o[g], col_o[g]}, 0);
    end
    #2 rst = 1'b0;

    // ---------------- full square, always ready, latency
    b_beats = nbeats[0];
    push_expected(0);
    @(negedge clk);
    pulse_start(0);
    @(negedge clk);
    check("busy_run", busy[0], 1);
    check("lat_e0", vld[0], 0);
    @(negedge clk);
    @(negedge clk);
    check("lat_e2", vld[0], 0);
    @(negedge clk);
    check("lat_e3", vld[0], 1);
    wait_done(0, 2000);
    check("beats_full", 32'(nbeats[0] - b_beats), 64);
    check("q_empty_full", 32'(exp_q[0].size()), 0);
    check("busy_after", busy[0], 0);

    // ---------------- full square, random backpressure
    rmode = 1;
    repeat (2) @(posedge clk);
    b_beats = nbeats[0];
    push_expected(0);
    @(negedge clk);
    pulse_start(0);
    wait_done(0, 4000);
    check("beats_lfsr", 32'(nbeats[0] - b_beats), 64);
    check("q_empty_lfsr", 32'(exp_q[0].size()), 0);
    rmode = 0;
    repeat (2) @(posedge clk);

    // ---------------- lower triangle
    b_beats = nbeats[1]; b_first = nfirst[1]; b_last = nlast[1];
    push_expected(1);
    @(negedge clk);
    pulse_start(1);
    wait_done(1, 2000);
    check("beats_tri", 32'(nbeats[1] - b_beats), 40);
    check("first_tri", 32'(nfirst[1] - b_first), 10);
    check("last_tri",  32'(nlast[1] - b_last), 10);
    check("q_empty_tri", 32'(exp_q[1].size()), 0);

    // ---------------- start during RUN and DRAIN is ignored
    b_beats = nbeats[0]; b_done = ndone[0];
    push_expected(0);
    @(negedge clk);
    pulse_start(0);
    repeat (10) @(negedge clk);
    pulse_start(0);
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (exp_q[0].size() == 1) break;
    end
    check("drain_busy", busy[0], 1);
    pulse_start(0);
    wait_done(0, 2000);
    repeat (10) @(negedge clk);
    check("no_restart_busy", busy[0], 0);
    check("single_done", 32'(ndone[0] - b_done), 1);
    check("beats_restart", 32'(nbeats[0] - b_beats), 64);

    // ---------------- reset mid-pass, then replay from beat 0
    b_beats = nbeats[0];
    push_expected(0);
    @(negedge clk);
    pulse_start(0);
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (nbeats[0] - b_beats >= 20) break;
    end
    #2 rst = 1'b1;
    #1;
    check("arst_valid", vld[0], 0);
    check("arst_busy",  busy[0], 0);
    check("arst_ops",   {xo[0], zo[0]}, 0);
    check("arst_addr",  {a0[0], ca[0]}, 0);
    check("arst_tags",  {first_o[0], row_o[0], col_o[0]}, 0);
    repeat (2) @(negedge clk);
    exp_q[0].delete();
    #2 rst = 1'b0;
    b_beats = nbeats[0];
    push_expected(0);
    @(negedge clk);
    pulse_start(0);
    wait_done(0, 2000);
    check("beats_replay", 32'(nbeats[0] - b_beats), 64);

    // ---------------- 50-cycle stall from the first valid
    rmode = 2;
    repeat (2) @(posedge clk);
    b_beats = nbeats[0];
    push_expected(0);
    @(negedge clk);
    pulse_start(0);
    repeat (4) @(negedge clk);
    check("stall_first_valid", vld[0], 1);
    // Frozen pipeline: beat 0 at the output, beat 1 in the RAM stage,
    // beat 2 (i=0, j=0, k=2) addresses in S1.
    for (int c = 0; c < 50; c++) begin
      check("stall_valid", vld[0], 1);
      check("stall_mem_en", mem_en[0], 0);
      check("stall_addr", {a0[0], a1[0], b0[0], b1[0], ca[0]},
                          {4'd2, 4'd2, 4'd2, 4'd2, 4'd0});
      @(negedge clk);
    end
    rmode = 0;
    wait_done(0, 2000);
    check("beats_stall", 32'(nbeats[0] - b_beats), 64);
    check("q_empty_stall", 32'(exp_q[0].size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
